// File: rtl/multiphase_clock_gen.sv
// multiphase_clock_gen: NUM_PH interleaved phase outputs with run-time period/duty/delay config.
// Define MPCLK_DEADTIME_EN to add cfg_dead and the complementary ph_out_n outputs with dead time.
module multiphase_clock_gen #(
    parameter int NUM_PH     = 4,
    parameter int CNT_W      = 16,
    parameter int DEF_PERIOD = 1000,
    parameter int DEF_DUTY   = 500
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CNT_W-1:0]  cfg_period,
    input  logic [CNT_W-1:0]  cfg_duty,
    input  logic [CNT_W-1:0]  cfg_delay,
`ifdef MPCLK_DEADTIME_EN
    input  logic [CNT_W-1:0]  cfg_dead,
    output logic [NUM_PH-1:0] ph_out_n,
`endif
    output logic [NUM_PH-1:0] ph_out,
    output logic              sync_pulse,
    output logic              running
);
    localparam int LW = $clog2(NUM_PH);
    typedef enum logic [1:0] {IDLE, DELAY, RUN} state_t;
    state_t st, st_n;
    logic [CNT_W-1:0] cnt, cnt_n, dcnt, dcnt_n;
    logic [CNT_W-1:0] per_a, duty_a, dly_a, per_p, duty_p;
    logic [CNT_W-1:0] per_nx, duty_nx, dly_nx, dead_nx, per_c, cur_c;
    logic pend, pend_n, xfer, wrap, apply;
    logic [NUM_PH-1:0] ph_nx;
    assign cfg_ready = ~pend;
    assign xfer      = cfg_valid && cfg_ready;
    assign cur_c     = per_a < CNT_W'(2) ? CNT_W'(2) : per_a;
    assign wrap      = cnt == cur_c - 1'b1;
    assign apply     = st == RUN && wrap && pend;
    // Values the active config will hold after this edge; outputs are registered from them.
    assign per_nx    = (st != RUN && xfer) ? cfg_period : apply ? per_p : per_a;
    assign duty_nx   = (st != RUN && xfer) ? cfg_duty : apply ? duty_p : duty_a;
    assign dly_nx    = xfer ? cfg_delay : dly_a;
    assign per_c     = per_nx < CNT_W'(2) ? CNT_W'(2) : per_nx;
    assign pend_n    = st == RUN && (xfer || (pend && !wrap));
`ifdef MPCLK_DEADTIME_EN
    logic [CNT_W-1:0] dead_a, dead_p;
    logic [NUM_PH-1:0] ph_n_nx;
    assign dead_nx = (st != RUN && xfer) ? cfg_dead : apply ? dead_p : dead_a;
    always_ff @(posedge clk) begin
        if (rst) begin
            dead_a   <= '0;
            dead_p   <= '0;
            ph_out_n <= '0;
        end else begin
            dead_a   <= dead_nx;
            dead_p   <= (st == RUN && xfer) ? cfg_dead : dead_p;
            ph_out_n <= st_n == RUN ? ph_n_nx : '0;
        end
    end
`else
    assign dead_nx = '0;
`endif
    always_comb begin
        st_n   = st;
        cnt_n  = '0;
        dcnt_n = '0;
        if (st == IDLE) begin
            st_n   = !enable ? IDLE : dly_nx != '0 ? DELAY : RUN;
            dcnt_n = dly_nx;
        end else if (st == DELAY) begin
            st_n   = !enable ? IDLE : dcnt == CNT_W'(1) ? RUN : DELAY;
            dcnt_n = dcnt - 1'b1;
        end else begin
            st_n  = (wrap && !enable) ? IDLE : RUN;
            cnt_n = wrap ? '0 : cnt + 1'b1;
        end
    end
    for (genvar k = 0; k < NUM_PH; k++) begin : g_ph
        logic [CNT_W+4:0] prod;
        logic [CNT_W-1:0] off;
        logic [CNT_W:0]   pos;
        assign prod     = (CNT_W+5)'(k) * (CNT_W+5)'(per_c);
        assign off      = CNT_W'(prod >> LW);
        assign pos      = cnt_n >= off ? {1'b0, cnt_n - off}
                                       : {1'b0, cnt_n} + {1'b0, per_c} - {1'b0, off};
        assign ph_nx[k] = pos >= {1'b0, dead_nx} && pos < {1'b0, duty_nx};
`ifdef MPCLK_DEADTIME_EN
        assign ph_n_nx[k] = pos >= {1'b0, duty_nx} + {1'b0, dead_nx} && pos < {1'b0, per_c};
`endif
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            st         <= IDLE;
            cnt        <= '0;
            dcnt       <= '0;
            per_a      <= CNT_W'(DEF_PERIOD);
            duty_a     <= CNT_W'(DEF_DUTY);
            dly_a      <= '0;
            per_p      <= '0;
            duty_p     <= '0;
            pend       <= 1'b0;
            ph_out     <= '0;
            sync_pulse <= 1'b0;
            running    <= 1'b0;
        end else begin
            st         <= st_n;
            cnt        <= cnt_n;
            dcnt       <= st_n == DELAY ? dcnt_n : '0;
            per_a      <= per_nx;
            duty_a     <= duty_nx;
            dly_a      <= dly_nx;
            per_p      <= (st == RUN && xfer) ? cfg_period : per_p;
            duty_p     <= (st == RUN && xfer) ? cfg_duty : duty_p;
            pend       <= pend_n;
            ph_out     <= st_n == RUN ? ph_nx : '0;
            sync_pulse <= st_n == RUN && cnt_n == '0;
            running    <= st_n == RUN;
        end
    end
endmodule

// File: tb/tb_multiphase_clock_gen.sv
// tb_multiphase_clock_gen: directed checks of reset, phasing, delay, reconfig, clamping and stop.
module tb_multiphase_clock_gen;
    logic clk = 1'b0;
    logic rst, enable, cfg_valid, cfg_ready, sync_pulse, running;
    logic [15:0] cfg_period, cfg_duty, cfg_delay;
    logic [3:0] ph_out;
`ifdef MPCLK_DEADTIME_EN
    logic [15:0] cfg_dead;
    logic [3:0] ph_out_n;
`endif
    int nchk = 0;
    int nerr = 0;
    logic act;
    logic [3:0] tab8 [8]  = '{4'b1001, 4'b1001, 4'b0011, 4'b0011, 4'b0110, 4'b0110, 4'b1100, 4'b1100};
    logic [3:0] tab12 [12] = '{4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0010,
                               4'b0100, 4'b0100, 4'b0100, 4'b1000, 4'b1000, 4'b1000};

    multiphase_clock_gen dut (
        .clk(clk), .rst(rst), .enable(enable), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_period(cfg_period), .cfg_duty(cfg_duty), .cfg_delay(cfg_delay),
`ifdef MPCLK_DEADTIME_EN
        .cfg_dead(cfg_dead), .ph_out_n(ph_out_n),
`endif
        .ph_out(ph_out), .sync_pulse(sync_pulse), .running(running)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cfg(input logic [15:0] p, input logic [15:0] d, input logic [15:0] dl,
                       input logic [15:0] dd);
        cfg_period = p;
        cfg_duty   = d;
        cfg_delay  = dl;
`ifdef MPCLK_DEADTIME_EN
        cfg_dead   = dd;
`endif
        cfg_valid  = 1'b1;
        tick();
        cfg_valid  = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; enable = 1'b0; cfg_valid = 1'b0;
        cfg_period = '0; cfg_duty = '0; cfg_delay = '0;
`ifdef MPCLK_DEADTIME_EN
        cfg_dead = '0;
`endif
        #1;
        tick(3);
        chk("rst_ph", ph_out, 0);
        chk("rst_sync", sync_pulse, 0);
        chk("rst_run", running, 0);
        chk("rst_ready", cfg_ready, 1);
        rst = 1'b0;
        act = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            tick();
            act = act | (|ph_out) | sync_pulse | running | !cfg_ready;
        end
        chk("idle_quiet", act, 0);

        // four-phase basic: P=8 D=4 delay=0
        cfg(8, 4, 0, 0);
        chk("idle_cfg_ready", cfg_ready, 1);
        chk("idle_cfg_run", running, 0);
        enable = 1'b1;
        tick();
        chk("start_run", running, 1);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("p8_ph_%0d", i), ph_out, tab8[i % 8]);
            chk($sformatf("p8_sync_%0d", i), sync_pulse, (i % 8) == 0);
            tick();
        end

        // mid-run reconfig to P=12 D=3 offered at cnt=3
        tick(3);
        chk("rc_ready_cnt3", cfg_ready, 1);
        cfg(12, 3, 0, 0);
        chk("rc_ready_cnt4", cfg_ready, 0);
        chk("rc_ph_cnt4", ph_out, 4'b0110);
        tick(3);
        chk("rc_ready_cnt7", cfg_ready, 0);
        chk("rc_ph_cnt7", ph_out, 4'b1100);
        tick();
        chk("rc_ready_wrap", cfg_ready, 1);
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("p12_ph_%0d", i), ph_out, tab12[i]);
            chk($sformatf("p12_sync_%0d", i), sync_pulse, i == 0);
            tick();
        end
        chk("p12_sync_next", sync_pulse, 1);

        // back to P=8, then stop with enable dropped at cnt=2
        cfg(8, 4, 0, 0);
        tick(11);
        chk("back8_sync", sync_pulse, 1);
        chk("back8_ph", ph_out, 4'b1001);
        tick(2);
        enable = 1'b0;
        tick();
        chk("stop_cnt3_run", running, 1);
        tick(4);
        chk("stop_cnt7_run", running, 1);
        chk("stop_cnt7_ph", ph_out, 4'b1100);
        tick();
        chk("stop_run", running, 0);
        chk("stop_ph", ph_out, 0);
        chk("stop_sync", sync_pulse, 0);
        tick(3);
        chk("stop_stays", running, 0);

        // D=P gives constant 1, then D=0 gives constant 0
        cfg(8, 8, 0, 0);
        enable = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("dfull_ph_%0d", i), ph_out, 4'b1111);
            tick();
        end
        cfg(8, 0, 0, 0);
        tick(7);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("dzero_ph_%0d", i), ph_out, 0);
            chk($sformatf("dzero_run_%0d", i), running, 1);
            tick();
        end

        // P=1 clamps to P=2; offsets 0,0,1,1 with D=1
        cfg(1, 1, 0, 0);
        tick(7);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("p2_ph_%0d", i), ph_out, (i % 2) == 0 ? 4'b0011 : 4'b1100);
            chk($sformatf("p2_sync_%0d", i), sync_pulse, (i % 2) == 0);
            tick();
        end

        // rst at cnt=5 with a pending config discards it
        cfg(8, 4, 0, 0);
        tick();
        chk("prerst_sync", sync_pulse, 1);
        chk("prerst_ph", ph_out, 4'b1001);
        cfg(12, 3, 0, 0);
        chk("prerst_pend", cfg_ready, 0);
        tick(4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid_run", running, 0);
        chk("rst_mid_ph", ph_out, 0);
        chk("rst_mid_ready", cfg_ready, 1);
        tick();
        chk("def_sync", sync_pulse, 1);
        chk("def_ph", ph_out, 4'b1001);
        tick(12);
        chk("def_cnt12_sync", sync_pulse, 0);
        chk("def_cnt12_ph", ph_out, 4'b1001);
        chk("def_cnt12_run", running, 1);

        // start delay of 5 cycles
        rst = 1'b1; enable = 1'b0;
        tick();
        rst = 1'b0;
        cfg(8, 4, 5, 0);
        enable = 1'b1;
        tick();
        chk("dly_e0_run", running, 0);
        for (int i = 1; i < 5; i++) begin
            tick();
            chk($sformatf("dly_e%0d_sync", i), sync_pulse, 0);
            chk($sformatf("dly_e%0d_run", i), running, 0);
        end
        tick();
        chk("dly_first_sync", sync_pulse, 1);
        chk("dly_first_run", running, 1);
        chk("dly_first_ph", ph_out, 4'b1001);

`ifdef MPCLK_DEADTIME_EN
        // dead time: P=10 D=5 dead=1
        rst = 1'b1; enable = 1'b0;
        tick();
        rst = 1'b0;
        chk("dt_rst_n", ph_out_n, 0);
        cfg(10, 5, 0, 1);
        enable = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("dt_ph0_%0d", i), ph_out[0], i >= 1 && i <= 4);
            chk($sformatf("dt_phn0_%0d", i), ph_out_n[0], i >= 6);
            chk($sformatf("dt_ovl_%0d", i), ph_out & ph_out_n, 0);
            tick();
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
